// File: rtl/pwm_sched_ctrl_if.sv
// Config and PWM-output bundle for pwm_sched_ctrl.
// The master side drives control and config writes; the slave side returns counter and PWM status.
interface pwm_sched_ctrl_if #(
  parameter int NUM_CNT_BITS = 8,
  parameter int NUM_CH       = 4,
  parameter int ADDR_BITS    = 3
);
  logic                    start;
  logic                    stop;
  logic                    commit;
  logic                    wr_en;
  logic [ADDR_BITS-1:0]    wr_addr;
  logic [NUM_CNT_BITS-1:0] wr_data;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    period_done;
  logic                    update_ack;
  logic                    busy;
  logic                    cfg_err;

  modport master (
    output start, stop, commit,
    output wr_en, wr_addr, wr_data,
    input  count_out, pwm_out,
    input  period_done, update_ack,
    input  busy, cfg_err
  );

  modport slave (
    input  start, stop, commit,
    input  wr_en, wr_addr, wr_data,
    output count_out, pwm_out,
    output period_done, update_ack,
    output busy, cfg_err
  );
endinterface

// File: rtl/pwm_sched_ctrl.sv
// Shared period counter for NUM_CH PWM channels.
// Shadow period/duty registers are copied to the active set at start or at a committed wrap.
module pwm_sched_ctrl #(
  parameter int NUM_CNT_BITS = 8,
  parameter int NUM_CH       = 4,
  parameter int ADDR_BITS    = 3
) (
  input logic              clk,
  input logic              n_rst,
  pwm_sched_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_e;

  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  state_e                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CNT_BITS-1:0] period_sh_q;
  logic [NUM_CNT_BITS-1:0] period_a_q;
  logic [NUM_CNT_BITS-1:0] duty_sh_q [NUM_CH];
  logic [NUM_CNT_BITS-1:0] duty_a_q  [NUM_CH];
  logic [NUM_CNT_BITS-1:0] duty_n    [NUM_CH];
  logic [NUM_CH-1:0]       pwm_q, pwm_d;
  logic                    pend_q, pend_d;
  logic                    err_q, err_d;
  logic                    ack_q, ack_d;
  logic                    load;
  logic                    wrap;

  assign wrap = (state_q != IDLE) && (count_q == period_a_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pend_d  = pend_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (period_sh_q != '0) begin
            state_d = RUN;
            load    = 1'b1;
            count_d = ONE;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.stop) state_d = STOPPING;
      end
      STOPPING: begin
        if (!bus.stop && bus.start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) begin
      count_d = wrap ? ONE : count_q + ONE;
      pend_d  = pend_q | bus.commit;
      if (wrap) begin
        // a commit arriving on the wrap cycle waits for the next wrap
        pend_d = bus.commit;
        if (pend_q) begin
          if (period_sh_q != '0) begin
            load  = 1'b1;
            ack_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (state_q == STOPPING && state_d == STOPPING) begin
          state_d = IDLE;
          count_d = '0;
          pend_d  = 1'b0;
          load    = 1'b0;
          ack_d   = 1'b0;
          err_d   = err_q;
        end
      end
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      duty_n[i] = load ? duty_sh_q[i] : duty_a_q[i];
      pwm_d[i]  = (state_d != IDLE) && (count_d != '0) &&
                  (count_d <= duty_n[i]);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      period_sh_q <= '0;
      period_a_q  <= '0;
      pwm_q       <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh_q[i] <= '0;
        duty_a_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pwm_q   <= pwm_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      if (load) begin
        period_a_q <= period_sh_q;
        for (int i = 0; i < NUM_CH; i++) duty_a_q[i] <= duty_sh_q[i];
      end
      if (bus.wr_en && bus.wr_addr == '0) period_sh_q <= bus.wr_data;
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.wr_en && bus.wr_addr == ADDR_BITS'(i + 1))
          duty_sh_q[i] <= bus.wr_data;
      end
    end
  end

  assign bus.count_out   = count_q;
  assign bus.pwm_out     = pwm_q;
  assign bus.period_done = wrap;
  assign bus.update_ack  = ack_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.cfg_err     = err_q;
endmodule

// File: tb/tb_pwm_sched_ctrl.sv
// Bench for pwm_sched_ctrl: vector table, directed corner sequences, random run vs model.
// Model tracks the run/stop/commit rules directly and derives outputs from them.
module tb_pwm_sched_ctrl;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pwm_sched_ctrl_if #(.NUM_CNT_BITS(8), .NUM_CH(4), .ADDR_BITS(3)) bus ();

  pwm_sched_ctrl #(.NUM_CNT_BITS(8), .NUM_CH(4), .ADDR_BITS(3)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // model: 0 idle, 1 running, 2 stopping
  int         mst;
  logic [7:0] mcnt, mper, mpsh;
  logic [7:0] mduty [4];
  logic [7:0] mdsh  [4];
  bit         mpend, merr, mack;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mst = 0; mcnt = 0; mper = 0; mpsh = 0;
    mpend = 0; merr = 0; mack = 0;
    for (int i = 0; i < 4; i++) begin
      mduty[i] = 0;
      mdsh[i]  = 0;
    end
  endtask

  function automatic logic [3:0] m_pwm();
    logic [3:0] p = '0;
    for (int i = 0; i < 4; i++)
      p[i] = (mst != 0) && (mcnt >= 1) && (mcnt <= mduty[i]);
    return p;
  endfunction

  task automatic model_step(input bit st, sp, cm, we,
                            input logic [2:0] wa, input logic [7:0] wd);
    bit wrap = (mst != 0) && (mcnt == mper);
    bit ld = 0;
    int ns;
    mack = 0;
    if (mst == 0) begin
      if (st && !sp) begin
        if (mpsh != 0) begin
          mst = 1; mcnt = 1; merr = 0; ld = 1;
        end else merr = 1;
      end
    end else begin
      ns = sp ? 2 : (st ? 1 : mst);
      if (wrap && mst == 2 && ns == 2) begin
        mst = 0; mcnt = 0; mpend = 0;
      end else begin
        mst = ns;
        if (wrap) begin
          mcnt = 1;
          if (mpend) begin
            if (mpsh != 0) begin ld = 1; mack = 1; end
            else merr = 1;
          end
          mpend = cm;
        end else begin
          mcnt = mcnt + 8'd1;
          mpend = mpend | cm;
        end
      end
    end
    if (ld) begin
      mper = mpsh;
      for (int i = 0; i < 4; i++) mduty[i] = mdsh[i];
    end
    if (we) begin
      if (wa == 0) mpsh = wd;
      else if (wa <= 4) mdsh[wa-1] = wd;
    end
  endtask

  task automatic cmp_model();
    chk("count", bus.count_out, mcnt);
    chk("pwm", bus.pwm_out, m_pwm());
    chk("done", bus.period_done, (mst != 0) && (mcnt == mper));
    chk("ack", bus.update_ack, mack);
    chk("busy", bus.busy, mst != 0);
    chk("err", bus.cfg_err, merr);
  endtask

  task automatic cyc(input bit st, sp, cm, we,
                     input logic [2:0] wa, input logic [7:0] wd);
    bus.start = st; bus.stop = sp; bus.commit = cm;
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    @(posedge clk);
    model_step(st, sp, cm, we, wa, wd);
    #1;
    cmp_model();
    bus.start = 0; bus.stop = 0; bus.commit = 0; bus.wr_en = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 3'd0, 8'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cyc(0, 0, 0, 1, a, d);
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    int n = 0;
    while (mcnt != v && n < 300) begin
      idle(1);
      n++;
    end
    chk("wait_cnt_timeout", n < 300, 1);
  endtask

  typedef struct {
    bit         st, sp, cm, we;
    logic [2:0] wa;
    logic [7:0] wd;
    int         ecnt, epwm, edone, eack, ebusy, eerr;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1,0,0,0,3'd0,8'd0, 0,0,0,0,0,1};
    tbl[1] = '{0,0,0,1,3'd0,8'd4, 0,0,0,0,0,1};
    tbl[2] = '{0,0,0,1,3'd1,8'd2, 0,0,0,0,0,1};
    tbl[3] = '{1,0,0,0,3'd0,8'd0, 1,1,0,0,1,0};
    tbl[4] = '{0,0,0,0,3'd0,8'd0, 2,1,0,0,1,0};
    tbl[5] = '{0,0,0,0,3'd0,8'd0, 3,0,0,0,1,0};
    tbl[6] = '{0,0,0,0,3'd0,8'd0, 4,0,1,0,1,0};
    tbl[7] = '{0,0,0,0,3'd0,8'd0, 1,1,0,0,1,0};
    tbl[8] = '{0,0,0,0,3'd0,8'd0, 2,1,0,0,1,0};

    bus.start = 0; bus.stop = 0; bus.commit = 0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_model();
    n_rst = 1'b1;

    // reset-start error, basic run period 4 duty0 2
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].st, tbl[i].sp, tbl[i].cm, tbl[i].we, tbl[i].wa, tbl[i].wd);
      chk($sformatf("tbl%0d_cnt", i), bus.count_out, tbl[i].ecnt);
      chk($sformatf("tbl%0d_pwm", i), bus.pwm_out, tbl[i].epwm);
      chk($sformatf("tbl%0d_done", i), bus.period_done, tbl[i].edone);
      chk($sformatf("tbl%0d_ack", i), bus.update_ack, tbl[i].eack);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].ebusy);
      chk($sformatf("tbl%0d_err", i), bus.cfg_err, tbl[i].eerr);
    end

    // shadow duty write + commit takes effect only at wrap
    wr(3'd1, 8'd3);
    cyc(0, 0, 1, 0, 3'd0, 8'd0);
    chk("upd_pre_cnt", bus.count_out, 4);
    chk("upd_pre_pwm0", bus.pwm_out[0], 0);
    idle(1);
    chk("upd_ack", bus.update_ack, 1);
    chk("upd_pwm0_c1", bus.pwm_out[0], 1);
    idle(2);
    chk("upd_pwm0_c3", bus.pwm_out[0], 1);
    idle(1);
    chk("upd_pwm0_c4", bus.pwm_out[0], 0);

    // duty 0 / equal / above period
    wr(3'd2, 8'd0);
    wr(3'd3, 8'd4);
    wr(3'd4, 8'd9);
    cyc(0, 0, 1, 0, 3'd0, 8'd0);
    begin
      int n = 0;
      while (!mack && n < 20) begin idle(1); n++; end
      chk("edge_duty_timeout", n < 20, 1);
    end
    for (int i = 0; i < 8; i++) begin
      chk("edge_duty_pwm", bus.pwm_out[3:1], 3'b110);
      idle(1);
    end

    // stop completes at period end
    wait_cnt(8'd2);
    cyc(0, 1, 0, 0, 3'd0, 8'd0);
    chk("stop_busy3", bus.busy, 1);
    idle(1);
    chk("stop_done4", bus.period_done, 1);
    chk("stop_busy4", bus.busy, 1);
    idle(1);
    chk("stop_idle_busy", bus.busy, 0);
    chk("stop_idle_cnt", bus.count_out, 0);
    chk("stop_idle_pwm", bus.pwm_out, 0);

    // start during STOPPING cancels the stop
    cyc(1, 0, 0, 0, 3'd0, 8'd0);
    wait_cnt(8'd2);
    cyc(0, 1, 0, 0, 3'd0, 8'd0);
    cyc(1, 0, 0, 0, 3'd0, 8'd0);
    chk("restart_cnt4", bus.count_out, 4);
    idle(1);
    chk("restart_busy", bus.busy, 1);
    chk("restart_cnt1", bus.count_out, 1);

    // committing with period shadow 0 keeps old period
    wr(3'd0, 8'd0);
    cyc(0, 0, 1, 0, 3'd0, 8'd0);
    wait_cnt(8'd1);
    chk("cerr_flag", bus.cfg_err, 1);
    chk("cerr_noack", bus.update_ack, 0);
    wait_cnt(8'd4);
    chk("cerr_old_period", bus.period_done, 1);
    wr(3'd0, 8'd4);

    // async reset mid-period
    wait_cnt(8'd3);
    n_rst = 1'b0;
    #1;
    model_reset();
    chk("rst_cnt", bus.count_out, 0);
    chk("rst_pwm", bus.pwm_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.period_done, 0);
    chk("rst_err", bus.cfg_err, 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    wr(3'd0, 8'd5);
    cyc(1, 0, 0, 0, 3'd0, 8'd0);
    chk("rst_restart_cnt", bus.count_out, 1);

    // random traffic against model
    for (int i = 0; i < 3000; i++) begin
      bit st = ($urandom_range(0, 15) == 0);
      bit sp = ($urandom_range(0, 23) == 0);
      bit cm = ($urandom_range(0, 9) == 0);
      bit we = ($urandom_range(0, 3) == 0);
      logic [2:0] wa = 3'($urandom_range(0, 7));
      logic [7:0] wd = ($urandom_range(0, 40) == 0) ? 8'd255
                       : 8'($urandom_range(0, 6));
      cyc(st, sp, cm, we, wa, wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
